// File: rtl/bf_pkg.sv
// Shared BF encodings: command opcodes (also decoded by bf_control),
// loader state encoding and loader error codes.
package bf_pkg;

  localparam logic [3:0] OP_LT     = 4'd0;
  localparam logic [3:0] OP_GT     = 4'd1;
  localparam logic [3:0] OP_PLUS   = 4'd2;
  localparam logic [3:0] OP_MINUS  = 4'd3;
  localparam logic [3:0] OP_LBRACK = 4'd4;
  localparam logic [3:0] OP_RBRACK = 4'd5;
  localparam logic [3:0] OP_DOT    = 4'd6;
  localparam logic [3:0] OP_COMMA  = 4'd7;
  localparam logic [3:0] OP_STOP   = 4'hF;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_UNMATCHED = 2'b01;
  localparam logic [1:0] ERR_UNCLOSED  = 2'b10;
  localparam logic [1:0] ERR_TOO_LONG  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WSTOP = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4,
    S_ERRH  = 3'd5
  } ld_state_e;

endpackage

// File: rtl/bf_program_loader_if.sv
// Loader bus: byte stream in from the host receiver, opcode writes out to
// program memory. master = loader side, slave = host/memory side.
interface bf_program_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wdata;

  modport master (input rx_data, rx_valid,
                  output rx_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (output rx_data, rx_valid,
                  input rx_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/bf_ascii_decode.sv
// ASCII byte -> BF opcode. Anything that is not one of the eight commands
// reports is_cmd=0 (comment byte).
module bf_ascii_decode
  import bf_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_cmd,
  output logic [3:0] opcode
);

  always_comb begin
    is_cmd = 1'b1;
    opcode = OP_STOP;
    case (byte_i)
      8'h3C:   opcode = OP_LT;     // '<'
      8'h3E:   opcode = OP_GT;     // '>'
      8'h2B:   opcode = OP_PLUS;   // '+'
      8'h2D:   opcode = OP_MINUS;  // '-'
      8'h5B:   opcode = OP_LBRACK; // '['
      8'h5D:   opcode = OP_RBRACK; // ']'
      8'h2E:   opcode = OP_DOT;    // '.'
      8'h2C:   opcode = OP_COMMA;  // ','
      default: is_cmd = 1'b0;
    endcase
  end

endmodule

// File: rtl/bf_program_loader.sv
// Streams an ASCII BF program into program memory as opcodes, checks bracket
// balance and terminates it with STOP; on error plants STOP at address 0.
module bf_program_loader
  import bf_pkg::*;
#(
  parameter int         ADDR_W   = 8,
  parameter int         DEPTH    = 256,
  parameter int         BDEPTH_W = 8,
  parameter logic [7:0] TERM     = 8'h21
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  bf_program_loader_if.master    bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic [ADDR_W-1:0]      prog_len
);

  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [BDEPTH_W-1:0] BD_MAX    = '1;

  ld_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     wp_q, wp_d;
  logic [BDEPTH_W-1:0]   bd_q, bd_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [3:0]            mem_wdata_q, mem_wdata_d;

  logic                  is_cmd;
  logic [3:0]            opcode;
  logic                  accept;
  logic                  fail;
  logic [1:0]            fail_code;

  bf_ascii_decode u_dec (
    .byte_i (bus.rx_data),
    .is_cmd (is_cmd),
    .opcode (opcode)
  );

  assign accept = bus.rx_valid && (state_q == S_RECV);

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    bd_d        = bd_q;
    err_code_d  = err_code_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fail        = 1'b0;
    fail_code   = ERR_NONE;

    case (state_q)
      S_IDLE, S_DONE, S_ERRH: begin
        if (start) begin
          state_d    = S_RECV;
          wp_d       = '0;
          bd_d       = '0;
          err_code_d = ERR_NONE;
        end
      end
      S_RECV: begin
        if (accept) begin
          if (bus.rx_data == TERM) begin
            if (bd_q != '0) begin
              fail      = 1'b1;
              fail_code = ERR_UNCLOSED;
            end else begin
              state_d     = S_WSTOP;
              mem_we_d    = 1'b1;
              mem_addr_d  = wp_q;
              mem_wdata_d = OP_STOP;
            end
          end else if (is_cmd) begin
            // The last address is kept for STOP, so a command there overflows.
            if (wp_q == LAST_ADDR) begin
              fail      = 1'b1;
              fail_code = ERR_TOO_LONG;
            end else if (opcode == OP_RBRACK && bd_q == '0) begin
              fail      = 1'b1;
              fail_code = ERR_UNMATCHED;
            end else if (opcode == OP_LBRACK && bd_q == BD_MAX) begin
              fail      = 1'b1;
              fail_code = ERR_UNCLOSED;
            end else begin
              mem_we_d    = 1'b1;
              mem_addr_d  = wp_q;
              mem_wdata_d = opcode;
              wp_d        = wp_q + 1'b1;
              if (opcode == OP_LBRACK) bd_d = bd_q + 1'b1;
              if (opcode == OP_RBRACK) bd_d = bd_q - 1'b1;
            end
          end
        end
      end
      S_WSTOP: state_d = S_DONE;
      S_ERR:   state_d = S_ERRH;
      default: state_d = S_IDLE;
    endcase

    // Error write lands during the ERR cycle: STOP at 0 halts the CPU at once.
    if (fail) begin
      state_d     = S_ERR;
      err_code_d  = fail_code;
      mem_we_d    = 1'b1;
      mem_addr_d  = '0;
      mem_wdata_d = OP_STOP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wp_q        <= '0;
      bd_q        <= '0;
      err_code_q  <= ERR_NONE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      bd_q        <= bd_d;
      err_code_q  <= err_code_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.rx_ready  = (state_q == S_RECV);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign busy     = (state_q == S_RECV) || (state_q == S_WSTOP) || (state_q == S_ERR);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERRH);
  assign err_code = err_code_q;
  assign prog_len = wp_q;

endmodule
